// File: rtl/tpu_pkg.sv
// Shared definitions for the TPU pooling datapath: default sample width,
// pooling mode encoding and a lane-offset helper. Optional macro: MAXPOOL_STREAM_SIGNED_EN.
package tpu_pkg;

    localparam int DATA_W_DEF = 8;

    typedef enum logic {
        POOL_MAX = 1'b0,
        POOL_AVG = 1'b1
    } pool_mode_e;

    // Bit offset of lane 'lane' in a bus of equally sized lanes.
    function automatic int lane_lsb(input int lane, input int width);
        return lane * width;
    endfunction

endpackage

// File: rtl/pool_combine.sv
// One-channel pooling combiner: max of two operands, or their full-width sum.
// MAXPOOL_STREAM_SIGNED_EN selects two's-complement operands.
module pool_combine
    import tpu_pkg::*;
#(
    parameter int IN_W = 8
) (
    input  logic [IN_W-1:0] a_i,
    input  logic [IN_W-1:0] b_i,
    input  logic            mode_i,
    output logic [IN_W:0]   y_o
);

`ifdef MAXPOOL_STREAM_SIGNED_EN
    // Sign-extend one bit so the sum cannot overflow and max compares signed.
    logic signed [IN_W:0] a_x;
    logic signed [IN_W:0] b_x;
    logic signed [IN_W:0] y_x;

    assign a_x = {a_i[IN_W-1], a_i};
    assign b_x = {b_i[IN_W-1], b_i};

    always_comb begin
        y_x = a_x;
        if (mode_i == POOL_AVG) begin
            y_x = a_x + b_x;
        end else if (b_x > a_x) begin
            y_x = b_x;
        end
    end

    assign y_o = y_x;
`else
    logic [IN_W:0] a_x;
    logic [IN_W:0] b_x;

    assign a_x = {1'b0, a_i};
    assign b_x = {1'b0, b_i};

    always_comb begin
        y_o = a_x;
        if (mode_i == POOL_AVG) begin
            y_o = a_x + b_x;
        end else if (b_x > a_x) begin
            y_o = b_x;
        end
    end
`endif

endmodule

// File: rtl/maxpool_stream.sv
// Streaming 2x2 stride-2 max/average pooling with a half-row line buffer.
// Optional macro: MAXPOOL_STREAM_SIGNED_EN (two's-complement samples).
module maxpool_stream
    import tpu_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int CH     = 1,
    parameter int IMG_W  = 24,
    parameter int IMG_H  = 24
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 pool_mode,
    input  logic                 s_valid,
    output logic                 s_ready,
    input  logic [CH*DATA_W-1:0] s_data,
    output logic                 m_valid,
    input  logic                 m_ready,
    output logic [CH*DATA_W-1:0] m_data,
    output logic                 m_last,
    output logic                 frame_done
);

    localparam int COL_W = (IMG_W > 2) ? $clog2(IMG_W) : 1;
    localparam int ROW_W = (IMG_H > 2) ? $clog2(IMG_H) : 1;
    localparam int HALF  = IMG_W / 2;
    localparam int LB_AW = (HALF > 1) ? $clog2(HALF) : 1;
    localparam int PW    = DATA_W + 1;
    localparam int VW    = DATA_W + 2;

    logic [COL_W-1:0]       col_q, col_d;
    logic [ROW_W-1:0]       row_q, row_d;
    logic                   mode_q, mode_d;
    logic [CH*DATA_W-1:0]   h_reg_q, h_reg_d;
    logic                   m_valid_q, m_valid_d;
    logic [CH*DATA_W-1:0]   m_data_q, m_data_d;
    logic                   m_last_q, m_last_d;
    logic                   frame_done_q, frame_done_d;

    logic [CH*PW-1:0]       lbuf_q [HALF];
    logic [CH*PW-1:0]       lb_rd;
    logic [CH*PW-1:0]       pair;
    logic [CH*VW-1:0]       vert;
    logic [CH*DATA_W-1:0]   result;
    logic [LB_AW-1:0]       lb_idx;

    logic accept;
    logic last_col;
    logic last_row;

    // Downstream slot is free, or is being emptied this cycle.
    assign s_ready  = !m_valid_q || m_ready;
    assign accept   = s_valid && s_ready;
    assign last_col = (col_q == COL_W'(IMG_W - 1));
    assign last_row = (row_q == ROW_W'(IMG_H - 1));
    assign lb_idx   = LB_AW'(col_q >> 1);
    assign lb_rd    = lbuf_q[lb_idx];

    for (genvar c = 0; c < CH; c++) begin : g_lane
        pool_combine #(.IN_W(DATA_W)) u_pair (
            .a_i    (h_reg_q[lane_lsb(c, DATA_W) +: DATA_W]),
            .b_i    (s_data[lane_lsb(c, DATA_W) +: DATA_W]),
            .mode_i (mode_q),
            .y_o    (pair[lane_lsb(c, PW) +: PW])
        );

        pool_combine #(.IN_W(PW)) u_vert (
            .a_i    (lb_rd[lane_lsb(c, PW) +: PW]),
            .b_i    (pair[lane_lsb(c, PW) +: PW]),
            .mode_i (mode_q),
            .y_o    (vert[lane_lsb(c, VW) +: VW])
        );

        // Average drops the two LSBs of the 4-sample sum (floor; arithmetic when signed).
        assign result[lane_lsb(c, DATA_W) +: DATA_W] = (mode_q == POOL_AVG)
            ? vert[lane_lsb(c, VW) + 2 +: DATA_W]
            : vert[lane_lsb(c, VW) +: DATA_W];
    end

    always_comb begin
        col_d        = col_q;
        row_d        = row_q;
        mode_d       = mode_q;
        h_reg_d      = h_reg_q;
        m_valid_d    = m_valid_q;
        m_data_d     = m_data_q;
        m_last_d     = m_last_q;
        frame_done_d = 1'b0;

        if (m_valid_q && m_ready) begin
            m_valid_d = 1'b0;
        end

        if (accept) begin
            if (col_q == '0 && row_q == '0) begin
                mode_d = pool_mode;
            end

            if (!col_q[0]) begin
                h_reg_d = s_data;
            end else if (row_q[0]) begin
                m_valid_d = 1'b1;
                m_data_d  = result;
                m_last_d  = last_col && last_row;
            end

            if (last_col) begin
                col_d = '0;
                row_d = last_row ? '0 : row_q + ROW_W'(1);
            end else begin
                col_d = col_q + COL_W'(1);
            end

            frame_done_d = last_col && last_row;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            col_q        <= '0;
            row_q        <= '0;
            mode_q       <= POOL_MAX;
            h_reg_q      <= '0;
            m_valid_q    <= 1'b0;
            m_data_q     <= '0;
            m_last_q     <= 1'b0;
            frame_done_q <= 1'b0;
        end else begin
            col_q        <= col_d;
            row_q        <= row_d;
            mode_q       <= mode_d;
            h_reg_q      <= h_reg_d;
            m_valid_q    <= m_valid_d;
            m_data_q     <= m_data_d;
            m_last_q     <= m_last_d;
            frame_done_q <= frame_done_d;
        end
    end

    // Line buffer holds even-row pair results; it is fully rewritten every frame.
    always_ff @(posedge clk) begin
        if (accept && col_q[0] && !row_q[0]) begin
            lbuf_q[lb_idx] <= pair;
        end
    end

    assign m_valid    = m_valid_q;
    assign m_data     = m_data_q;
    assign m_last     = m_last_q;
    assign frame_done = frame_done_q;

endmodule

// File: tb/tb_maxpool_stream.sv
// Self-checking bench for maxpool_stream on a 4x4, two-lane configuration.
// Honours MAXPOOL_STREAM_SIGNED_EN in its reference model.
module tb_maxpool_stream;

    localparam int DW   = 8;
    localparam int CH   = 2;
    localparam int IW   = 4;
    localparam int IH   = 4;
    localparam int NPIX = IW * IH;
    localparam int NOUT = NPIX / 4;
    localparam int BW   = CH * DW;

    logic          clk = 1'b0;
    logic          rst;
    logic          pool_mode;
    logic          s_valid;
    logic          s_ready;
    logic [BW-1:0] s_data;
    logic          m_valid;
    logic          m_ready;
    logic [BW-1:0] m_data;
    logic          m_last;
    logic          frame_done;

    always #5 clk = ~clk;

    maxpool_stream #(
        .DATA_W (DW),
        .CH     (CH),
        .IMG_W  (IW),
        .IMG_H  (IH)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .pool_mode  (pool_mode),
        .s_valid    (s_valid),
        .s_ready    (s_ready),
        .s_data     (s_data),
        .m_valid    (m_valid),
        .m_ready    (m_ready),
        .m_data     (m_data),
        .m_last     (m_last),
        .frame_done (frame_done)
    );

    int            n_checks = 0;
    int            n_fail   = 0;
    logic [BW-1:0] frm [NPIX];
    logic [BW-1:0] exp_q [$];
    logic [BW-1:0] got_q [$];
    logic          got_last_q [$];
    int            fd_cyc_q [$];
    int            cyc = 0;
    int            last_acc_cyc = 0;
    int            hold_changes = 0;
    int            sready_viol = 0;
    logic          prev_stall = 1'b0;
    logic [BW-1:0] prev_data = '0;
    logic          prev_last = 1'b0;

    // ---------------- clock/reset and driver tasks ----------------
    task automatic cycle(input logic v, input logic [BW-1:0] d, input logic mode,
                         input logic rdy, output logic acc);
        @(negedge clk);
        s_valid   = v;
        s_data    = d;
        pool_mode = mode;
        m_ready   = rdy;
        #1;
        cyc++;
        acc = v && s_ready;
        if (frame_done) fd_cyc_q.push_back(cyc);
        if (prev_stall && (m_valid !== 1'b1 || m_data !== prev_data || m_last !== prev_last))
            hold_changes++;
        if (m_valid && !m_ready && s_ready) sready_viol++;
        if (m_valid && m_ready) begin
            got_q.push_back(m_data);
            got_last_q.push_back(m_last);
        end
        prev_stall = m_valid && !m_ready;
        prev_data  = m_data;
        prev_last  = m_last;
    endtask

    task automatic send_frame(input int first, input int last, input logic mode,
                              input int toggle_at, input int rdy_pct, input int budget,
                              output int next_idx, output int used);
        logic acc;
        int   idx;
        idx  = first;
        used = 0;
        while (idx < last && used < budget) begin
            cycle(1'b1, frm[idx], (idx >= toggle_at) ? ~mode : mode,
                  ($urandom_range(99) < rdy_pct), acc);
            used++;
            if (acc) begin
                if (idx == NPIX - 1) last_acc_cyc = cyc;
                idx++;
            end
        end
        next_idx = idx;
    endtask

    task automatic drain(input int n);
        logic acc;
        for (int i = 0; i < n; i++) cycle(1'b0, '0, 1'b0, 1'b1, acc);
    endtask

    task automatic fill_frame(input bit ramp);
        logic [BW-1:0] w;
        for (int i = 0; i < NPIX; i++) begin
            w = {$urandom, $urandom};
            if (ramp) w[DW-1:0] = DW'(i);
            frm[i] = w;
        end
    endtask

    // ---------------- reference model ----------------
    function automatic int to_int(input logic [DW-1:0] x);
`ifdef MAXPOOL_STREAM_SIGNED_EN
        return int'(signed'(x));
`else
        return int'(x);
`endif
    endfunction

    task automatic expect_frame(input logic mode);
        logic [BW-1:0] word;
        logic [BW-1:0] px;
        int v [4];
        int s, q;
        for (int r = 0; r < IH; r += 2) begin
            for (int c = 0; c < IW; c += 2) begin
                word = '0;
                for (int l = 0; l < CH; l++) begin
                    px = frm[r*IW + c];         v[0] = to_int(px[l*DW +: DW]);
                    px = frm[r*IW + c + 1];     v[1] = to_int(px[l*DW +: DW]);
                    px = frm[(r+1)*IW + c];     v[2] = to_int(px[l*DW +: DW]);
                    px = frm[(r+1)*IW + c + 1]; v[3] = to_int(px[l*DW +: DW]);
                    if (mode) begin
                        s = v[0] + v[1] + v[2] + v[3];
                        q = s / 4;
                        if (s < 0 && (s % 4) != 0) q = q - 1;
                    end else begin
                        q = v[0];
                        for (int k = 1; k < 4; k++) if (v[k] > q) q = v[k];
                    end
                    word[l*DW +: DW] = DW'(q);
                end
                exp_q.push_back(word);
            end
        end
    endtask

    task automatic clear_obs();
        got_q.delete();
        got_last_q.delete();
        exp_q.delete();
        fd_cyc_q.delete();
        hold_changes = 0;
        sready_viol  = 0;
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        rst = 1'b1; s_valid = 1'b0; s_data = '0; pool_mode = 1'b0; m_ready = 1'b0;
        repeat (3) @(negedge clk);
        #1;
        n_checks++; if (m_valid !== 1'b0) begin n_fail++; $display("FAIL reset_m_valid: got %b expected 0", m_valid); end
        n_checks++; if (m_data !== '0) begin n_fail++; $display("FAIL reset_m_data: got %h expected 0", m_data); end
        n_checks++; if (m_last !== 1'b0) begin n_fail++; $display("FAIL reset_m_last: got %b expected 0", m_last); end
        n_checks++; if (frame_done !== 1'b0) begin n_fail++; $display("FAIL reset_frame_done: got %b expected 0", frame_done); end
        n_checks++; if (s_ready !== 1'b1) begin n_fail++; $display("FAIL reset_s_ready: got %b expected 1", s_ready); end
        @(negedge clk);
        rst = 1'b0;
        prev_stall = 1'b0;
    endtask

    task automatic test_directed(input logic mode);
        int k_max [NOUT] = '{5, 7, 13, 15};
        int k_avg [NOUT] = '{2, 4, 10, 12};
        logic [BW-1:0] g;
        int nx, used;
        clear_obs();
        fill_frame(1'b1);
        expect_frame(mode);
        send_frame(0, NPIX, mode, NPIX, 100, 200, nx, used);
        drain(4);
        n_checks++; if (got_q.size() != NOUT) begin n_fail++; $display("FAIL dir_count mode%0d: got %0d expected %0d", mode, got_q.size(), NOUT); end
        for (int i = 0; i < NOUT; i++) begin
            g = got_q[i];
            n_checks++; if (g !== exp_q[i]) begin n_fail++; $display("FAIL dir_data mode%0d #%0d: got %h expected %h", mode, i, g, exp_q[i]); end
            n_checks++; if (g[DW-1:0] !== DW'(mode ? k_avg[i] : k_max[i])) begin n_fail++; $display("FAIL dir_lane0 mode%0d #%0d: got %0d expected %0d", mode, i, g[DW-1:0], mode ? k_avg[i] : k_max[i]); end
            n_checks++; if (got_last_q[i] !== (i == NOUT - 1)) begin n_fail++; $display("FAIL dir_last mode%0d #%0d: got %b expected %b", mode, i, got_last_q[i], i == NOUT - 1); end
        end
        n_checks++; if (fd_cyc_q.size() != 1 || fd_cyc_q[0] != last_acc_cyc + 1) begin n_fail++; $display("FAIL dir_frame_done mode%0d: pulses %0d expected 1 at cycle %0d", mode, fd_cyc_q.size(), last_acc_cyc + 1); end
    endtask

    task automatic test_backpressure();
        logic [BW-1:0] g;
        int nx, used;
        clear_obs();
        fill_frame(1'b1);
        expect_frame(1'b0);
        send_frame(0, NPIX, 1'b0, NPIX, 0, 30, nx, used);
        n_checks++; if (nx != 6) begin n_fail++; $display("FAIL bp_accepted: got %0d expected 6", nx); end
        n_checks++; if (m_valid !== 1'b1 || m_data[DW-1:0] !== DW'(5)) begin n_fail++; $display("FAIL bp_hold_value: got valid %b data %0d expected valid 1 data 5", m_valid, m_data[DW-1:0]); end
        n_checks++; if (s_ready !== 1'b0) begin n_fail++; $display("FAIL bp_s_ready: got %b expected 0", s_ready); end
        n_checks++; if (hold_changes != 0) begin n_fail++; $display("FAIL bp_stable: got %0d changes expected 0", hold_changes); end
        n_checks++; if (sready_viol != 0) begin n_fail++; $display("FAIL bp_ready_rule: got %0d violations expected 0", sready_viol); end
        send_frame(nx, NPIX, 1'b0, NPIX, 100, 200, nx, used);
        drain(4);
        n_checks++; if (got_q.size() != NOUT) begin n_fail++; $display("FAIL bp_count: got %0d expected %0d", got_q.size(), NOUT); end
        for (int i = 0; i < NOUT; i++) begin
            g = got_q[i];
            n_checks++; if (g !== exp_q[i]) begin n_fail++; $display("FAIL bp_data #%0d: got %h expected %h", i, g, exp_q[i]); end
        end
    endtask

    task automatic test_mode_toggle();
        int nx, used;
        clear_obs();
        fill_frame(1'b1);
        expect_frame(1'b0);
        send_frame(0, NPIX, 1'b0, 6, 100, 200, nx, used);
        fill_frame(1'b0);
        expect_frame(1'b1);
        send_frame(0, NPIX, 1'b1, NPIX, 100, 200, nx, used);
        drain(4);
        n_checks++; if (got_q.size() != 2 * NOUT) begin n_fail++; $display("FAIL toggle_count: got %0d expected %0d", got_q.size(), 2 * NOUT); end
        for (int i = 0; i < 2 * NOUT; i++) begin
            n_checks++; if (got_q[i] !== exp_q[i]) begin n_fail++; $display("FAIL toggle_data #%0d: got %h expected %h", i, got_q[i], exp_q[i]); end
        end
    endtask

    task automatic test_reset_mid_frame();
        int nx, used;
        clear_obs();
        fill_frame(1'b1);
        send_frame(0, 9, 1'b0, NPIX, 100, 100, nx, used);
        @(negedge clk);
        rst = 1'b1; s_valid = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        #1;
        n_checks++; if (m_valid !== 1'b0) begin n_fail++; $display("FAIL rstmid_m_valid: got %b expected 0", m_valid); end
        clear_obs();
        prev_stall = 1'b0;
        expect_frame(1'b0);
        send_frame(0, NPIX, 1'b0, NPIX, 100, 200, nx, used);
        drain(4);
        n_checks++; if (got_q.size() != NOUT) begin n_fail++; $display("FAIL rstmid_count: got %0d expected %0d", got_q.size(), NOUT); end
        for (int i = 0; i < NOUT; i++) begin
            n_checks++; if (got_q[i] !== exp_q[i]) begin n_fail++; $display("FAIL rstmid_data #%0d: got %h expected %h", i, got_q[i], exp_q[i]); end
        end
    endtask

    task automatic test_back_to_back();
        logic mode;
        int nx, used;
        clear_obs();
        for (int f = 0; f < 3; f++) begin
            mode = 1'($urandom_range(1));
            fill_frame(1'b0);
            expect_frame(mode);
            send_frame(0, NPIX, mode, NPIX, 100, 200, nx, used);
            n_checks++; if (used != NPIX) begin n_fail++; $display("FAIL b2b_throughput f%0d: got %0d cycles expected %0d", f, used, NPIX); end
        end
        for (int f = 0; f < 2; f++) begin
            mode = 1'($urandom_range(1));
            fill_frame(1'b0);
            expect_frame(mode);
            send_frame(0, NPIX, mode, NPIX, 60, 600, nx, used);
            n_checks++; if (nx != NPIX) begin n_fail++; $display("FAIL b2b_timeout f%0d: got %0d beats expected %0d", f, nx, NPIX); end
        end
        drain(6);
        n_checks++; if (got_q.size() != exp_q.size()) begin n_fail++; $display("FAIL b2b_count: got %0d expected %0d", got_q.size(), exp_q.size()); end
        for (int i = 0; i < exp_q.size(); i++) begin
            n_checks++; if (got_q[i] !== exp_q[i]) begin n_fail++; $display("FAIL b2b_data #%0d: got %h expected %h", i, got_q[i], exp_q[i]); end
        end
        n_checks++; if (fd_cyc_q.size() != 5) begin n_fail++; $display("FAIL b2b_frame_done: got %0d pulses expected 5", fd_cyc_q.size()); end
        n_checks++; if (hold_changes != 0) begin n_fail++; $display("FAIL b2b_stable: got %0d changes expected 0", hold_changes); end
    endtask

    task automatic test_sign_edge();
        logic [BW-1:0] g;
        logic [BW-1:0] w;
        int nx, used;
        for (int m = 1; m >= 0; m--) begin
            clear_obs();
            fill_frame(1'b0);
            for (int i = 0; i < NPIX; i++) begin
                w = frm[i];
                w[DW-1:0] = '0;
                frm[i] = w;
            end
`ifdef MAXPOOL_STREAM_SIGNED_EN
            w = frm[0]; w[DW-1:0] = 8'hFF; frm[0] = w;
            w = frm[1]; w[DW-1:0] = 8'hFF; frm[1] = w;
            w = frm[4]; w[DW-1:0] = 8'hFF; frm[4] = w;
            w = frm[5]; w[DW-1:0] = 8'hFE; frm[5] = w;
`else
            w = frm[0]; w[DW-1:0] = 8'hFF; frm[0] = w;
            w = frm[1]; w[DW-1:0] = 8'h01; frm[1] = w;
`endif
            expect_frame(1'(m));
            send_frame(0, NPIX, 1'(m), NPIX, 100, 200, nx, used);
            drain(4);
            g = got_q[0];
`ifdef MAXPOOL_STREAM_SIGNED_EN
            n_checks++; if (g[DW-1:0] !== ((m == 1) ? 8'hFE : 8'hFF)) begin n_fail++; $display("FAIL sign_window mode%0d: got %h expected %h", m, g[DW-1:0], (m == 1) ? 8'hFE : 8'hFF); end
`else
            n_checks++; if (g[DW-1:0] !== ((m == 1) ? 8'h40 : 8'hFF)) begin n_fail++; $display("FAIL sign_window mode%0d: got %h expected %h", m, g[DW-1:0], (m == 1) ? 8'h40 : 8'hFF); end
`endif
            for (int i = 0; i < NOUT; i++) begin
                n_checks++; if (got_q[i] !== exp_q[i]) begin n_fail++; $display("FAIL sign_data mode%0d #%0d: got %h expected %h", m, i, got_q[i], exp_q[i]); end
            end
        end
    endtask

    // ---------------- sequence and report ----------------
    initial begin
        test_reset();
        test_directed(1'b0);
        test_directed(1'b1);
        test_backpressure();
        test_mode_toggle();
        test_reset_mid_frame();
        test_back_to_back();
        test_sign_edge();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/maxpool_stream.md
Name: maxpool_stream

Overview:
- Streaming 2x2 stride-2 pooling engine; successor to the combinational 24x24→12x12 pool.
- Accepts one pixel per beat in raster order, CH channels in parallel lanes, over a valid/ready handshake.
- Emits one pooled pixel per 2x2 window.
- Sits between a conv/ReLU stage and the next TPU layer; needs only a half-row line buffer instead of the full tensor.
- Adds a runtime max/average mode.

Parameters:
- DATA_W, 8, bits per channel sample.
- CH, 1, parallel channels per beat.
- IMG_W, 24, input columns; must be even and ≥2.
- IMG_H, 24, input rows; must be even and ≥2.

Ports:
- clk  in  1  clock; all logic is on the rising edge.
- rst  in  1  synchronous active-high reset.
- pool_mode  in  1  0 = max, 1 = average; sampled only at the frame-start beat.
- s_valid  in  1  input beat valid.
- s_ready  out  1  input beat accepted when s_valid && s_ready.
- s_data  in  CH*DATA_W  channel c in bits [c*DATA_W +: DATA_W].
- m_valid  out  1  pooled output valid.
- m_ready  in  1  downstream accepts.
- m_data  out  CH*DATA_W  pooled pixel, same lane layout as s_data.
- m_last  out  1  high with the final pooled pixel of a frame.
- frame_done  out  1  one-cycle pulse when the last input beat of a frame is accepted.

Behaviour:
- Reset: m_valid=0, m_data=0, m_last=0, frame_done=0, s_ready=1, col=0, row=0, mode_q=0, h_reg=0.
- Line buffer contents are not reset.
- Reset mid-frame discards the partial frame; the next accepted beat is pixel (0,0).
- Counters: col runs 0..IMG_W-1 and row runs 0..IMG_H-1, advancing only on accepted beats.
- col wraps to 0 and increments row; row wraps to 0 after (IMG_H-1, IMG_W-1).
- The beat at (0,0) loads mode_q from pool_mode; mid-frame changes to pool_mode are ignored.
- Even col: store the beat in h_reg.
- Odd col: form pair = combine(h_reg, beat) per channel.
  - Max mode: combine is max.
  - Average mode: combine is the sum, DATA_W+1 bits.
- Odd col, even row: write pair into lbuf[col/2]. lbuf has depth IMG_W/2 and width CH*(DATA_W+1).
- Odd col, odd row: result = combine(lbuf[col/2], pair).
  - Average mode: the sum is DATA_W+2 bits, then shifted right 2 (truncating floor), producing DATA_W bits.
  - The result loads the output register: m_valid=1 on the next cycle (latency 1 cycle from the accepting edge).
  - m_last=1 iff this is pixel (IMG_H-1, IMG_W-1).
- Output hold: m_valid, m_data and m_last stay stable while m_valid && !m_ready.
- s_ready = !m_valid || m_ready, computed combinationally. With a continuously ready sink, throughput is one input beat per cycle.
- Simultaneous events: same-cycle output handoff and new result load the new result; m_valid stays 1.
- frame_done pulses on the cycle after the (IMG_H-1, IMG_W-1) beat is accepted.
- Comparisons are unsigned by default; ties select either operand (the values are equal).

Optional Feature:
- Macro: MAXPOOL_STREAM_SIGNED_EN.
- Defined:
  - Samples are two's complement.
  - Max uses signed compare.
  - Sums are sign-extended and the average uses an arithmetic shift (floor toward −∞, e.g. avg(−1,−1,−1,−2) = −2).
  - Reset value of h_reg is 0.
- Undefined: all unsigned; the signed logic is absent.

Decomposition:
- Shared package tpu_pkg holds:
  - DATA_W default.
  - POOL_MAX=1'b0 and POOL_AVG=1'b1 mode constants.
  - Lane-slice helper function.
- One sub-module is natural: pool_combine (one channel; inputs a, b, mode; output max or sum; widths parametrised).
  - Instantiated CH times at the pair stage and CH times at the vertical stage.

Test Plan:
- IMG_W=IMG_H=4, CH=1, max mode, pixels 0..15 raster, m_ready=1 → outputs 5,7,13,15; m_last with 15; frame_done one cycle after the beat for pixel 15.
- Same frame, pool_mode=1 → outputs floor(10/4)=2, floor(18/4)=4, floor(42/4)=10, floor(50/4)=12.
- m_ready held 0 after the first output → m_data=5 held stable; s_ready=0; no input beats lost. After release, the remaining 7,13,15 appear in order.
- pool_mode toggled at pixel 6 of a max frame → all outputs still max. The next frame starting with pool_mode=1 yields averages.
- rst asserted after 9 beats, then a full fresh frame → only that frame's 4 outputs appear, values as in scenario 1.
- With MAXPOOL_STREAM_SIGNED_EN, window {−1,−1,−1,−2}: average → −2 (0xFE), max → −1 (0xFF). Without the macro, max of 0xFF vs 0x01 = 0xFF.
